// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite widths, response encoding and the identification word.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 6;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [AXI_DATA_W-1:0] AXI_ID_VALUE = 32'h414C_5331;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Byte-enabled register array; the highest index is a constant read-only ID word.
module axi_lite_regfile #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       IDX_W    = 4,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h414C_5331
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data_c
);

  localparam int unsigned       STRB_W = DATA_W / 8;
  localparam int unsigned       NUM_RW = (1 << IDX_W) - 1;
  localparam logic [IDX_W-1:0]  ID_IDX = IDX_W'(NUM_RW);

  logic [DATA_W-1:0] mem_q [NUM_RW];
  logic [DATA_W-1:0] mem_d [NUM_RW];

  // Merge enabled byte lanes; writes aimed at the ID slot are dropped.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_idx != ID_IDX)) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_c = (rd_idx == ID_IDX) ? ID_VALUE : mem_q[rd_idx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder over a 16-word register file with independent AW/W slots,
// a single outstanding B response and a single outstanding R response.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = AXI_ADDR_W,
  parameter int unsigned           DATA_WIDTH = AXI_DATA_W,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = AXI_ID_VALUE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    wr_pulse,
  output logic [ADDR_WIDTH-3:0]   wr_index
);

  localparam int unsigned       STRB_W = DATA_WIDTH / 8;
  localparam int unsigned       IDX_W  = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0]  ID_IDX = IDX_W'((1 << IDX_W) - 1);

  logic                  aw_full_q,  aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q,   aw_idx_d;
  logic                  w_full_q,   w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q,   w_data_d;
  logic [STRB_W-1:0]     w_strb_q,   w_strb_d;
  logic                  awready_q,  awready_d;
  logic                  wready_q,   wready_d;
  logic                  bvalid_q,   bvalid_d;
  resp_t                 bresp_q,    bresp_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]      wr_index_q, wr_index_d;
  logic                  arready_q,  arready_d;
  logic                  rvalid_q,   rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;

  logic                  aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  unused_c;

  assign unused_c = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  // Write side: slot capture, commit (bypassing a just-captured slot), B channel.
  always_comb begin
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_index_d = wr_index_q;
    wr_pulse_d = 1'b0;

    aw_hs_c = awvalid && awready_q;
    w_hs_c  = wvalid && wready_q;

    if (aw_hs_c) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs_c) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    // A held response blocks the commit even on its own handshake edge.
    commit_c = aw_full_d && w_full_d && !bvalid_q;

    if (commit_c) begin
      aw_full_d  = 1'b0;
      w_full_d   = 1'b0;
      bvalid_d   = 1'b1;
      bresp_d    = (aw_idx_d == ID_IDX) ? SLVERR : OKAY;
      wr_pulse_d = 1'b1;
      wr_index_d = aw_idx_d;
    end

    awready_d = !aw_full_d && !commit_c;
    wready_d  = !w_full_d && !commit_c;
  end

  // Read side: one outstanding beat, address accepted only while R is idle.
  always_comb begin
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ar_hs_c   = arvalid && arready_q;
    arready_d = !rvalid_q || rready;

    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs_c) begin
      rvalid_d  = 1'b1;
      rdata_d   = rd_data_c;
      arready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      wr_index_q <= wr_index_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  axi_lite_regfile #(
    .DATA_W   (DATA_WIDTH),
    .IDX_W    (IDX_W),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (commit_c),
    .wr_idx    (aw_idx_d),
    .wr_data   (w_data_d),
    .wr_strb   (w_strb_d),
    .rd_idx    (araddr[ADDR_WIDTH-1:2]),
    .rd_data_c (rd_data_c)
  );

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_index = wr_index_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = OKAY;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed table, corner sequences, random vs. model.
module tb_axi_lite_slave_regs;

  localparam int          CYC_MAX = 40;
  localparam logic [31:0] ID_WORD = 32'h414C_5331;

  logic        clk, reset_n;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, wr_pulse;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb, wr_index;
  logic [1:0]  bresp, rresp;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [16];

  typedef struct {
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    logic [3:0]  exp_idx;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  axi_lite_slave_regs dut (
    .clk(clk), .reset_n(reset_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: word array with byte-lane merge; index 15 is the fixed ID.
  function automatic logic [31:0] mdl_rd(input logic [3:0] i);
    return (i == 4'hF) ? ID_WORD : mdl[i];
  endfunction

  task automatic mdl_wr(input logic [3:0] i, input logic [31:0] d, input logic [3:0] s);
    if (i != 4'hF) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  function automatic vec_t mk_w(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                                input int awd, input int wd, input logic [1:0] r, input logic [3:0] i);
    vec_t v;
    v.is_wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.aw_dly = awd; v.w_dly = wd;
    v.exp_resp = r; v.exp_idx = i; v.exp_rdata = '0;
    return v;
  endfunction

  function automatic vec_t mk_r(input logic [5:0] a, input logic [31:0] e);
    vec_t v;
    v.is_wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.aw_dly = 0; v.w_dly = 0;
    v.exp_resp = '0; v.exp_idx = '0; v.exp_rdata = e;
    return v;
  endfunction

  task automatic do_aw(input logic [5:0] a, input int dly, input string nm);
    logic h;
    h = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
    for (int k = 0; k < CYC_MAX && !h; k++) begin
      h = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    chk({nm, "_awhs"}, 32'(h), 32'd1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input int dly, input string nm);
    logic h;
    h = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int k = 0; k < CYC_MAX && !h; k++) begin
      h = wready;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    chk({nm, "_whs"}, 32'(h), 32'd1);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input logic [1:0] er, input logic [3:0] ei,
                          input string nm);
    logic got;
    got = 1'b0;
    bready = 1'b1;
    fork
      do_aw(a, awd, nm);
      do_w(d, s, wd, nm);
    join
    for (int k = 0; k < CYC_MAX && !got; k++) begin
      if (bvalid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk({nm, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({nm, "_bresp"}, 32'(bresp), 32'(er));
    chk({nm, "_pulse"}, 32'(wr_pulse), 32'd1);
    chk({nm, "_index"}, 32'(wr_index), 32'(ei));
    @(posedge clk); #1;
    chk({nm, "_bdone"}, 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] e, input int stall, input string nm);
    logic h;
    h = 1'b0;
    rready = 1'b1;
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
    for (int k = 0; k < CYC_MAX && !h; k++) begin
      h = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    chk({nm, "_arhs"}, 32'(h), 32'd1);
    chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({nm, "_rdata"}, rdata, e);
    chk({nm, "_rresp"}, 32'(rresp), 32'd0);
    if (stall > 0) begin
      rready = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
        chk({nm, "_hold_rvalid"}, 32'(rvalid), 32'd1);
        chk({nm, "_hold_rdata"}, rdata, e);
        chk({nm, "_hold_arready"}, 32'(arready), 32'd0);
      end
      rready = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, "_rdone"}, 32'(rvalid), 32'd0);
    chk({nm, "_arready_back"}, 32'(arready), 32'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 32'({awready, wready, arready, bvalid, rvalid, wr_pulse}), 32'd0);
    chk({nm, "_codes"}, 32'({bresp, rresp, wr_index}), 32'd0);
    chk({nm, "_rdata"}, rdata, 32'd0);
  endtask

  logic [5:0]  ra;
  logic [31:0] rd;
  logic [3:0]  rs;

  initial begin
    reset_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    // Reset state and release.
    repeat (2) begin @(posedge clk); #1; end
    chk_all_zero("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_readies", 32'({awready, wready, arready}), 32'd7);

    // AW parked without W, then reset mid-transaction.
    do_aw(6'h20, 0, "park");
    repeat (2) begin @(posedge clk); #1; end
    chk("park_awready", 32'(awready), 32'd0);
    chk("park_no_b", 32'(bvalid), 32'd0);
    #3 reset_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_readies", 32'({awready, wready, arready}), 32'd7);
    do_read(6'h20, 32'h0, 0, "midrst_rd");
    chk("midrst_no_b", 32'(bvalid), 32'd0);

    // Directed table.
    tbl.push_back(mk_w(6'h08, 32'hDEADBEEF, 4'hF, 0, 2, 2'b00, 4'd2));
    tbl.push_back(mk_r(6'h08, 32'hDEADBEEF));
    tbl.push_back(mk_w(6'h04, 32'h11223344, 4'b0101, 2, 0, 2'b00, 4'd1));
    tbl.push_back(mk_r(6'h04, 32'h00220044));
    tbl.push_back(mk_w(6'h3C, 32'h12345678, 4'hF, 0, 0, 2'b10, 4'd15));
    tbl.push_back(mk_r(6'h3C, 32'h414C5331));
    tbl.push_back(mk_w(6'h06, 32'hAABBCCDD, 4'b1000, 1, 1, 2'b00, 4'd1));
    tbl.push_back(mk_r(6'h04, 32'hAA220044));
    tbl.push_back(mk_w(6'h10, 32'hFFFFFFFF, 4'b0000, 0, 0, 2'b00, 4'd4));
    tbl.push_back(mk_r(6'h10, 32'h00000000));
    tbl.push_back(mk_w(6'h0B, 32'h000000FF, 4'b0001, 0, 1, 2'b00, 4'd2));
    tbl.push_back(mk_r(6'h09, 32'hDEADBEFF));
    tbl.push_back(mk_w(6'h00, 32'hCAFEF00D, 4'hF, 0, 0, 2'b00, 4'd0));
    tbl.push_back(mk_w(6'h0C, 32'h01010101, 4'hF, 3, 1, 2'b00, 4'd3));
    tbl.push_back(mk_r(6'h00, 32'hCAFEF00D));
    tbl.push_back(mk_r(6'h3F, 32'h414C5331));

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly,
                 tbl[i].exp_resp, tbl[i].exp_idx, $sformatf("tbl%0d", i));
        mdl_wr(tbl[i].addr[5:2], tbl[i].data, tbl[i].strb);
      end else begin
        do_read(tbl[i].addr, tbl[i].exp_rdata, 0, $sformatf("tbl%0d", i));
      end
    end

    // R back-pressure: rready low for 4 cycles.
    do_read(6'h00, 32'hCAFEF00D, 4, "rstall");

    // AR handshake on the commit edge of the same word sees the old value.
    awaddr = 6'h0C; awvalid = 1'b1; wdata = 32'h02020202; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 6'h0C; arvalid = 1'b1;
    chk("same_readies", 32'({awready, wready, arready}), 32'd7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_rvalid", 32'(rvalid), 32'd1);
    chk("same_old", rdata, 32'h01010101);
    chk("same_bvalid", 32'(bvalid), 32'd1);
    chk("same_index", 32'(wr_index), 32'd3);
    chk("same_awready_n1", 32'(awready), 32'd0);
    @(posedge clk); #1;
    chk("same_bdone", 32'({bvalid, rvalid, wr_pulse}), 32'd0);
    chk("same_ready_n2", 32'({awready, wready}), 32'd3);
    mdl_wr(4'd3, 32'h02020202, 4'hF);
    do_read(6'h0C, 32'h02020202, 0, "same_new");

    // B back-pressure: second write fills its slots but cannot commit.
    bready = 1'b0;
    fork
      do_aw(6'h18, 0, "bs1");
      do_w(32'h5555AAAA, 4'hF, 0, "bs1");
    join
    chk("bs1_bvalid", 32'(bvalid), 32'd1);
    chk("bs1_index", 32'(wr_index), 32'd6);
    mdl_wr(4'd6, 32'h5555AAAA, 4'hF);
    awaddr = 6'h1C; awvalid = 1'b1; wdata = 32'h0F0FF0F0; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      automatic logic ah = awready;
      automatic logic wh = wready;
      @(posedge clk); #1;
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      chk($sformatf("bs_hold%0d_bvalid", i), 32'(bvalid), 32'd1);
      chk($sformatf("bs_hold%0d_pulse", i), 32'(wr_pulse), 32'd0);
    end
    chk("bs_slots_full", 32'({awready, wready}), 32'd0);
    chk("bs_resp_held", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    chk("bs_gap", 32'({bvalid, wr_pulse}), 32'd0);
    @(posedge clk); #1;
    chk("bs2_bvalid", 32'(bvalid), 32'd1);
    chk("bs2_pulse", 32'(wr_pulse), 32'd1);
    chk("bs2_index", 32'(wr_index), 32'd7);
    mdl_wr(4'd7, 32'h0F0FF0F0, 4'hF);
    @(posedge clk); #1;
    chk("bs2_bdone", 32'(bvalid), 32'd0);
    do_read(6'h18, mdl_rd(4'd6), 0, "bs1_rd");
    do_read(6'h1C, mdl_rd(4'd7), 1, "bs2_rd");

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      ra = 6'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        rd = $urandom;
        rs = 4'($urandom);
        do_write(ra, rd, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 (ra[5:2] == 4'hF) ? 2'b10 : 2'b00, ra[5:2], $sformatf("rnd%0d_wr", i));
        mdl_wr(ra[5:2], rd, rs);
      end else begin
        do_read(ra, mdl_rd(ra[5:2]), int'($urandom_range(0, 2)), $sformatf("rnd%0d_rd", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
